// File: rtl/rgb_seq_pkg.sv
// rtl/rgb_seq_pkg.sv - shared types and defaults for the RGB fade sequencer
package rgb_seq_pkg;

  localparam int PWM_BITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [PWM_BITS_DEF-1:0] r;
    logic [PWM_BITS_DEF-1:0] g;
    logic [PWM_BITS_DEF-1:0] b;
    logic [7:0]              hold;
  } cmd_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// rtl/rgb_pwm_channel.sv - registered PWM compare for one colour, active-low drive
module rgb_pwm_channel
  import rgb_seq_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] level,
  output logic                drive
);

  // pwm_cnt never reaches all-ones, so level==max keeps the LED permanently on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drive <= 1'b1;
    else        drive <= !(pwm_cnt < level);
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - queued RGB fade/hold sequencer with PWM outputs
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int PRESCALE    = 512,
  parameter int STEP_CYCLES = 33333,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_BITS-1:0] cmd_r,
  input  logic [PWM_BITS-1:0] cmd_g,
  input  logic [PWM_BITS-1:0] cmd_b,
  input  logic [7:0]          cmd_hold,
  output logic                busy,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                LED
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PWM_BITS-1:0] PWM_TOP = PWM_BITS'((1 << PWM_BITS) - 2);

  state_t              state, state_next;
  logic [SW-1:0]       step_cnt;
  logic [PW-1:0]       pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick, pre_tick;
  logic [PWM_BITS-1:0] cur_r, cur_g, cur_b;
  logic [PWM_BITS-1:0] cur_r_next, cur_g_next, cur_b_next;
  logic [PWM_BITS-1:0] target_r, target_g, target_b;
  logic [7:0]          hold_cnt;

  cmd_t                mem [FIFO_DEPTH];
  cmd_t                head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, count_next;
  logic                push, pop, empty;

  assign tick     = (step_cnt == SW'(STEP_CYCLES - 1));
  assign pre_tick = (pre_cnt == PW'(PRESCALE - 1));

  // Both timers free-run from reset; commands never realign them
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_cnt <= '0;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      pre_cnt  <= pre_tick ? '0 : pre_cnt + 1'b1;
      if (pre_tick) pwm_cnt <= (pwm_cnt == PWM_TOP) ? '0 : pwm_cnt + 1'b1;
    end
  end

  assign empty = (count == '0);
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state == IDLE) && !empty;
  assign head  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{r: cmd_r, g: cmd_g, b: cmd_b, hold: cmd_hold};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      cmd_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
    end
  end

  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  always_comb begin
    state_next = state;
    cur_r_next = cur_r;
    cur_g_next = cur_g;
    cur_b_next = cur_b;
    case (state)
      IDLE: if (!empty) state_next = FADE;
      FADE: if (tick) begin
        cur_r_next = step_toward(cur_r, target_r);
        cur_g_next = step_toward(cur_g, target_g);
        cur_b_next = step_toward(cur_b, target_b);
        if (cur_r_next == target_r && cur_g_next == target_g && cur_b_next == target_b)
          state_next = HOLD;
      end
      HOLD: if (tick && hold_cnt == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cur_r    <= '0;
      cur_g    <= '0;
      cur_b    <= '0;
      target_r <= '0;
      target_g <= '0;
      target_b <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      LED      <= 1'b1;
    end else begin
      state <= state_next;
      cur_r <= cur_r_next;
      cur_g <= cur_g_next;
      cur_b <= cur_b_next;
      if (pop) begin
        target_r <= head.r;
        target_g <= head.g;
        target_b <= head.b;
        hold_cnt <= head.hold;
      end else if (state == HOLD && tick && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      busy <= (state_next != IDLE) || (count_next != '0);
      LED  <= !((state_next != IDLE) || (count_next != '0));
    end
  end

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_r (
    .clk(CLK), .rst_n(RST_N), .pwm_cnt(pwm_cnt), .level(cur_r), .drive(RGB_R));
  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_g (
    .clk(CLK), .rst_n(RST_N), .pwm_cnt(pwm_cnt), .level(cur_g), .drive(RGB_G));
  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_b (
    .clk(CLK), .rst_n(RST_N), .pwm_cnt(pwm_cnt), .level(cur_b), .drive(RGB_B));

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb/tb_rgb_fade_sequencer.sv - self-checking bench for rgb_fade_sequencer
module tb_rgb_fade_sequencer;

  localparam int PB = 4;
  localparam int PS = 2;
  localparam int SC = 4;
  localparam int FD = 4;
  localparam int PERIOD = PS * ((1 << PB) - 1);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PB-1:0] cmd_r = '0, cmd_g = '0, cmd_b = '0;
  logic [7:0]    cmd_hold = '0;
  logic          busy, RGB_R, RGB_G, RGB_B, LED;

  rgb_fade_sequencer #(.PWM_BITS(PB), .PRESCALE(PS), .STEP_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .cmd_hold(cmd_hold),
    .busy(busy), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B), .LED(LED));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: per-command accept/pop/finish edge numbers, derived from
  // tick spacing, fade distance and hold length
  int n = 0;
  int acc_a [256];
  int pop_a [256];
  int end_a [256];
  int prev_end = 0;
  int m_r = 0, m_g = 0, m_b = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset();
    n = 0; prev_end = 0; m_r = 0; m_g = 0; m_b = 0;
  endfunction

  function automatic void model_accept(input int a, input int r, input int g, input int b, input int h);
    int p, t0, d, f;
    p  = ((a > prev_end) ? a : prev_end) + 1;
    t0 = ((p + SC) / SC) * SC;
    d  = iabs(r - m_r);
    if (iabs(g - m_g) > d) d = iabs(g - m_g);
    if (iabs(b - m_b) > d) d = iabs(b - m_b);
    f  = (d > 0) ? d : 1;
    acc_a[n] = a;
    pop_a[n] = p;
    end_a[n] = t0 + SC * (f + h);
    prev_end = end_a[n];
    m_r = r; m_g = g; m_b = b;
    n++;
  endfunction

  function automatic logic exp_busy();
    for (int i = 0; i < n; i++)
      if (acc_a[i] <= cyc && cyc < end_a[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready();
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (acc_a[i] <= cyc) c++;
      if (pop_a[i] <= cyc) c--;
    end
    return (c != FD);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (RST_N) cyc++;
    @(negedge CLK);
    if (RST_N) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy()});
      chk("led", {31'd0, LED}, {31'd0, !exp_busy()});
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready()});
    end
  endtask

  task automatic push(input int r, input int g, input int b, input int h);
    bit done;
    done = 0;
    cmd_r = PB'(r); cmd_g = PB'(g); cmd_b = PB'(b); cmd_hold = 8'(h);
    cmd_valid = 1'b1;
    for (int k = 0; k < 1000 && !done; k++) begin
      if (cmd_ready === 1'b1) begin
        model_accept(cyc + 1, r, g, b, h);
        done = 1;
      end
      step();
    end
    cmd_valid = 1'b0;
    chk("push_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 4000 && exp_busy(); k++) step();
    chk("idle_bound", {31'd0, exp_busy()}, 32'd0);
  endtask

  task automatic duty(input string tag, input int er, input int eg, input int eb);
    int lr, lg, lb;
    lr = 0; lg = 0; lb = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step();
      if (RGB_R === 1'b0) lr++;
      if (RGB_G === 1'b0) lg++;
      if (RGB_B === 1'b0) lb++;
    end
    chk({tag, "_r"}, lr, PS * er);
    chk({tag, "_g"}, lg, PS * eg);
    chk({tag, "_b"}, lb, PS * eb);
  endtask

  task automatic reset_checks();
    chk("rst_rgb", {29'd0, RGB_R, RGB_G, RGB_B}, 32'd7);
    chk("rst_led", {31'd0, LED}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    reset_checks();
    RST_N = 1'b1;
    cyc = 0;
    step();
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // Single red fade up, then hold
    push(15, 0, 0, 2);
    wait_idle();
    duty("red_full", 15, 0, 0);

    // Long fade running while the queue fills and stalls
    push(0, 15, 15, 1);
    for (int k = 0; k < 6; k++) step();
    for (int k = 0; k < 6; k++) begin
      push($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 2));
      if (k == 3) chk("fifo_full", {31'd0, cmd_ready}, 32'd0);
    end
    wait_idle();
    duty("burst_end", m_r, m_g, m_b);

    // Mixed-direction fade from white
    push(15, 15, 15, 0);
    wait_idle();
    push(0, 8, 15, 1);
    wait_idle();
    duty("mixed", 0, 8, 15);

    // Fractional duty, then a no-op command with zero hold
    push(5, 3, 12, 0);
    wait_idle();
    duty("dim", 5, 3, 12);
    push(5, 3, 12, 0);
    wait_idle();
    duty("same", 5, 3, 12);

    for (int k = 0; k < 8; k++) begin
      push($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
      for (int j = $urandom_range(0, 40); j > 0; j--) step();
    end
    wait_idle();
    duty("random", m_r, m_g, m_b);

    // Reset in the middle of a fade
    push(15, 15, 15, 3);
    push(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step();
    RST_N = 1'b0;
    #1;
    reset_checks();
    step();
    step();
    reset_checks();
    RST_N = 1'b1;
    cyc = 0;
    model_reset();
    step();
    chk("ready_after_midreset", {31'd0, cmd_ready}, 32'd1);
    duty("after_reset", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter PWM_BITS, default 4, meaning the intensity width per channel.
REQ-002 SHALL have parameter PRESCALE, default 512, meaning the number of clocks per PWM count advance.
REQ-003 SHALL have parameter STEP_CYCLES, default 33333, meaning the number of clocks per fade/hold step tick.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued commands (power of 2).
REQ-005 SHALL have port CLK, input, 1 bit: single 12 MHz clock; all state on posedge CLK.
REQ-006 SHALL have port RST_N, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit: FIFO can accept a command.
REQ-009 SHALL have ports cmd_r, cmd_g and cmd_b, input, PWM_BITS each: target intensities.
REQ-010 SHALL have port cmd_hold, input, 8 bits: step ticks to hold the target after arrival.
REQ-011 SHALL have port busy, output, 1 bit: a command is active or queued.
REQ-012 SHALL have ports RGB_R, RGB_G and RGB_B, output, 1 bit each: PWM drive, active-low.
REQ-013 SHALL have port LED, output, 1 bit: active-low status, low while busy.

Function
REQ-014 SHALL accept a command on any posedge with cmd_valid && cmd_ready; a command is never lost or duplicated.
REQ-015 SHALL drive cmd_ready as a register equal to !full for the next cycle; a push and a pop in the same cycle leave the occupancy unchanged.
REQ-016 SHALL implement states IDLE, FADE and HOLD.
REQ-017 IDLE: FIFO not empty -> pop the head into target_r/g/b and hold_cnt, then go to FADE the next cycle; FIFO empty -> stay in IDLE with cur_* unchanged.
REQ-018 FADE: on each step tick, each cur_x moves by +1, -1 or 0 toward target_x; when all three are equal after the update (or already equal on the tick) -> HOLD.
REQ-019 HOLD: on each step tick, hold_cnt==0 -> IDLE, else decrement; cmd_hold=0 exits on the first tick.
REQ-020 SHALL use a free-running step counter 0..STEP_CYCLES-1, pulsing the tick on the terminal value; the counter is not restarted by commands.
REQ-021 SHALL advance pwm_cnt every PRESCALE clocks over 0..2^PWM_BITS-2 and then wrap to 0 (period 2^PWM_BITS-1 counts).
REQ-022 SHALL register RGB_x = !(pwm_cnt < cur_x), one cycle of latency; cur=0 is always off and cur=max is always on.
REQ-023 SHALL set busy = (state != IDLE) || !empty and LED = !busy, both registered.
REQ-024 SHALL keep cur_* saturating: no wrap below 0 or above 2^PWM_BITS-1.

Reset
REQ-025 SHALL, while RST_N is low, force RGB_R/G/B=1, LED=1, busy=0, cmd_ready=0, cur_*=0, FIFO empty, state IDLE and all counters 0.
REQ-026 SHALL raise cmd_ready on the first posedge after RST_N deasserts; a reset during FADE or HOLD abandons the active command and flushes the queue.

Structure
REQ-027 SHALL place in package rgb_seq_pkg: the state enum, a command struct {r, g, b, hold}, and the PWM_BITS default.
REQ-028 SHALL instantiate sub-module rgb_pwm_channel three times; it is the compare-and-register for one colour and shares pwm_cnt.
REQ-029 SHALL keep the FIFO, FSM and timers inline within the 120-400 line budget.

Verification (PRESCALE=2, STEP_CYCLES=4, PWM_BITS=4)
REQ-030 Reset: assert RST_N=0 mid-run -> RGB=111, LED=1 and busy=0 immediately; cmd_ready=0, rising 1 cycle after release.
REQ-031 Push (15,0,0) hold=2 -> cur_r rises 1 per 4 clocks to 15 after 15 ticks, HOLD for 3 ticks, then IDLE; RGB_R stays low once cur_r=15.
REQ-032 Push 6 commands back-to-back while FADE is running a 15-step command -> 4 queued, cmd_ready low, 5th stalls until the pop; all executed in order.
REQ-033 From cur=(15,15,15) push (0,8,15) -> R ramps down 15 ticks, G stops at 8 after 7, B stays 15; HOLD is entered after tick 15.
REQ-034 Hold cur_r=5 -> RGB_R low for exactly 5 of every 15 PWM counts (10 of every 30 clocks).
REQ-035 Push a command equal to the current colour with hold=0 -> FADE->HOLD on the first tick, HOLD->IDLE on the next tick, RGB unchanged.
